// File: rtl/array_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : array_acc_stage
//  Description : Frame accumulator that follows the 16-bit array adder/
//                multiplier datapath. Each accepted result word {cout, s} is
//                treated as a 17-bit unsigned term and summed into a wide
//                accumulator. After 'len' terms have been accepted, the frame
//                total is presented downstream on a valid/ready handshake.
//                This lets multi-term dot products be built from the
//                single-cycle array results.
//
//  Ports       :
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous active-high reset
//    in_valid   in   1      upstream term present on s/cout
//    in_ready   out  1      a term can be accepted this cycle
//    s          in   16     sum/product word from the array stage
//    cout       in   1      carry from the array stage (term bit 16)
//    len        in   LEN_W  terms per frame, sampled on first beat; 0 = 2^LEN_W
//    out_valid  out  1      frame total available
//    out_ready  in   1      downstream accepts the total
//    acc_out    out  ACC_W  frame total modulo 2^ACC_W
//    ovf        out  1      carry out of the accumulator MSB during the frame
//    busy       out  1      a frame is in progress or being held
//
//  Revision    : 1.0  initial release
// ============================================================================
module array_acc_stage #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      s,
    input  logic             cout,
    input  logic [LEN_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_rem;
    logic             r_ovf;

    logic [ACC_W-1:0] w_term;
    logic [ACC_W:0]   w_sum;
    logic             w_accept;

    // Term zero-extended to the accumulator width.
    assign w_term = ACC_W'({cout, s});

    // One extra bit captures the carry out of the accumulator MSB.
    assign w_sum = {1'b0, r_acc} + {1'b0, w_term};

    // Handshake outputs are pure decodes of the state register, so there is
    // no combinational path from in_valid or out_ready to in_ready.
    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);

    assign w_accept  = in_valid && in_ready;

    assign acc_out   = r_acc;
    assign ovf       = r_ovf;

    // ------------------------------------------------------------------------
    // Control and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= w_term;
                        r_ovf <= 1'b0;
                        // len - 1 wraps to all-ones for len = 0, which is
                        // exactly 2^LEN_W - 1 remaining terms.
                        r_rem <= len - c_one;
                        if (len == c_one) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                        r_rem <= r_rem - c_one;
                        if (r_rem == c_one) begin
                            r_state <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // Total and overflow flag stay in place after release
                    // until the next frame's first accept overwrites them.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_array_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_acc_stage
//  Description : Self-checking bench for array_acc_stage. Expected frame
//                totals are pushed to a scoreboard queue as frames are driven
//                and compared when the DUT hands a total downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_acc_stage;

    localparam int ACC_W = 24;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      s;
    logic             cout;
    logic [LEN_W-1:0] len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             busy;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    array_acc_stage #(
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .cout      (cout),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected result from the plain integer sum of all terms in the frame:
    // since terms are non-negative, an overflow happened iff the total does
    // not fit in ACC_W bits.
    task automatic push_total(input longint total);
        exp_t e;
        e.acc = total[ACC_W-1:0];
        e.ovf = (total >= (64'd1 << ACC_W));
        sb.push_back(e);
    endtask

    // Offer one term until it is accepted; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] sv, input logic cv, input logic [LEN_W-1:0] lv);
        int n;
        n        = 0;
        in_valid = 1'b1;
        s        = sv;
        cout     = cv;
        len      = lv;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s        = 16'h0;
        cout     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output-side scoreboard: a handshake completes at the next rising edge
    // whenever both valid and ready are high at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_total", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_acc_out", 32'(acc_out), 32'(e.acc));
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        int gap;
        rst       = 1'b1;
        in_valid  = 1'b0;
        s         = 16'h0;
        cout      = 1'b0;
        len       = '0;
        out_ready = 1'b1;

        // Reset state
        idle(2);
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        idle(1);

        // Single-term frame
        push_total(64'h11234);
        send(16'h1234, 1'b1, 8'd1);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_in_ready_hold", 32'(in_ready), 32'd0);
        check("t1_acc_out", 32'(acc_out), 32'h011234);
        idle(1);
        check("t1_in_ready_after", 32'(in_ready), 32'd1);
        check("t1_out_valid_after", 32'(out_valid), 32'd0);

        // Four-term frame
        push_total(4 * 64'hFFFF);
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF, 1'b0, 8'd4);
            check("t2_out_valid", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        check("t2_acc_out", 32'(acc_out), 32'h03FFFC);

        // Wrap and overflow over a full 256-term frame
        push_total(256 * 64'h1FFFF);
        for (int i = 0; i < 256; i++) send(16'hFFFF, 1'b1, 8'd0);
        check("t3_acc_out", 32'(acc_out), 32'hFFFF00);
        check("t3_ovf", 32'(ovf), 32'd1);
        push_total(64'd1);
        send(16'h0001, 1'b0, 8'd1);
        check("t3b_acc_out", 32'(acc_out), 32'h000001);
        check("t3b_ovf", 32'(ovf), 32'd0);
        idle(1);

        // Backpressure: total must stay put and nothing gets absorbed
        out_ready = 1'b0;
        push_total(64'd7);
        send(16'd3, 1'b0, 8'd2);
        send(16'd4, 1'b0, 8'd2);
        in_valid = 1'b1;
        s        = 16'hAAAA;
        for (int i = 0; i < 10; i++) begin
            check("t4_in_ready", 32'(in_ready), 32'd0);
            check("t4_out_valid", 32'(out_valid), 32'd1);
            check("t4_acc_out", 32'(acc_out), 32'd7);
            idle(1);
        end
        in_valid  = 1'b0;
        s         = 16'h0;
        out_ready = 1'b1;
        idle(1);
        check("t4_out_valid_drop", 32'(out_valid), 32'd0);
        check("t4_acc_out_kept", 32'(acc_out), 32'd7);

        // Reset mid-frame discards the partial sum
        send(16'd1, 1'b0, 8'd4);
        send(16'd2, 1'b0, 8'd4);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_acc_out", 32'(acc_out), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        idle(1);
        push_total(64'd12);
        send(16'd5, 1'b0, 8'd2);
        send(16'd7, 1'b0, 8'd2);
        check("t5_acc_out_12", 32'(acc_out), 32'd12);
        idle(1);

        // Gaps between beats and a len change after the first beat
        push_total(64'd6);
        send(16'd1, 1'b0, 8'd3);
        gap = $urandom_range(0, 3);
        idle(gap);
        send(16'd2, 1'b0, 8'd1);
        check("t6_out_valid_mid", 32'(out_valid), 32'd0);
        gap = $urandom_range(0, 3);
        idle(gap);
        send(16'd3, 1'b0, 8'd1);
        check("t6_out_valid", 32'(out_valid), 32'd1);
        check("t6_acc_out", 32'(acc_out), 32'd6);

        idle(3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/array_acc_stage.md
Name: array_acc_stage

Overview:
- Downstream consumer of the 16-bit array adder/multiplier datapath.
- Takes each result word `{cout, s}` as a 17-bit unsigned term and accumulates a frame of `len` terms into a wide accumulator.
- Presents the frame total to the next stage on a valid/ready handshake.
- Provides the running-sum function the array datapath lacks, so multi-term dot products can be built from single-cycle results.

Parameters:
- `ACC_W`, default 24: accumulator and result width in bits; must be ≥ 17.
- `LEN_W`, default 8: width of the frame-length input; a frame holds 1 to 2^LEN_W terms.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  upstream term present on `s`/`cout`
- `in_ready`  output  1  block can accept a term this cycle
- `s`  input  16  sum/product word from the array stage
- `cout`  input  1  carry from the array stage; bit 16 of the term
- `len`  input  LEN_W  terms per frame; sampled on the first beat only; 0 means 2^LEN_W
- `out_valid`  output  1  frame total available
- `out_ready`  input  1  downstream accepts the total
- `acc_out`  output  ACC_W  frame total, modulo 2^ACC_W
- `ovf`  output  1  a carry out of bit ACC_W-1 occurred during the frame
- `busy`  output  1  a frame is in progress or being held (state ≠ IDLE)

Behaviour:
- Term value: `t = {cout, s}`, zero-extended to ACC_W. A beat is accepted when `in_valid && in_ready` at a rising edge.
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE; acc = 0; rem = 0; `ovf` = 0; `out_valid` = 0; `busy` = 0.
  - Partial frame is discarded. `acc_out` reads 0.
- State IDLE: `in_ready` = 1, `out_valid` = 0.
  - On accept: acc ← t, `ovf` ← 0, rem ← L-1, where L = `len`, or 2^LEN_W if `len` = 0.
  - Next state is HOLD if L = 1, otherwise ACCUM.
- State ACCUM: `in_ready` = 1.
  - On accept: acc ← acc + t (mod 2^ACC_W); `ovf` ← `ovf` | carry-out; rem ← rem-1.
  - If rem = 1 before the decrement, next state is HOLD.
  - No accept: everything holds. Gaps in `in_valid` of any length are allowed.
- State HOLD: `in_ready` = 0, `out_valid` = 1.
  - `acc_out` and `ovf` are stable while held.
  - On `out_ready`: next state is IDLE and `out_valid` drops the following cycle.
  - `acc_out`/`ovf` keep their last value until the next frame's first accept.
- Timing:
  - `in_ready` depends on state only; there is no combinational path from `out_ready` or `in_valid`.
  - `out_valid` rises the cycle after the last term is accepted (latency 1).
  - One bubble cycle occurs between frames: a term offered in the HOLD→IDLE handoff cycle is not accepted.
- Boundaries:
  - `len` changes after the first beat are ignored until the next frame.
  - `s`/`cout` are ignored when not accepted.
  - `out_ready` asserted outside HOLD has no effect.
  - `ovf` is sticky within a frame and cleared on the next frame's first accept.
- `acc_out` is driven directly from the acc register (registered output).

Test Plan:
- Single-term frame: `len`=1, `s`=0x1234, `cout`=1, `out_ready`=1 → one cycle after accept `out_valid`=1, `acc_out`=0x011234, `ovf`=0; `in_ready`=0 during that cycle, back to 1 the next.
- Four-term frame: `len`=4, four beats of `s`=0xFFFF, `cout`=0 → `acc_out`=0x03FFFC, `ovf`=0; `out_valid` stays 0 until the 4th accept.
- Wrap and overflow: `len`=0 (256 terms), each beat `cout`=1, `s`=0xFFFF → `acc_out`=0xFFFF00, `ovf`=1; the next frame (`len`=1, `s`=1) gives `acc_out`=0x000001, `ovf`=0.
- Backpressure: complete a `len`=2 frame (3, 4), hold `out_ready`=0 for 10 cycles while driving `in_valid`=1 with `s`=0xAAAA → `acc_out`=7 stable, `in_ready`=0, no term absorbed; `out_ready`=1 → `out_valid` falls the next cycle.
- Reset mid-frame: `len`=4, accept 2 terms, pulse `rst` between edges → outputs immediately 0 and `busy`=0; then `len`=2, terms 5 and 7 → `acc_out`=12.
- Gaps and `len` change: `len`=3, terms 1, 2, 3 with 0–3 idle cycles between beats; `len` changed to 1 after the first beat → `acc_out`=6 after exactly three accepts.
